// File: rtl/ddr3_width_fifo.sv
// Width-converting FWFT FIFO for the DDR3 user side: packs narrow words into wide entries or unpacks wide entries.
// Latency 1 cycle from completing commit to out_valid; backpressure in_ready=!full (and low while a flush is pending).
module ddr3_width_fifo #(
  parameter int              IN_W     = 16,
  parameter int              OUT_W    = 128,
  parameter int              DEPTH    = 256,
  parameter int              AF_LEVEL = 240,
  parameter int              AE_LEVEL = 4,
  parameter logic [IN_W-1:0] PAD      = '0,
  localparam int WIDE_W   = (IN_W > OUT_W) ? IN_W : OUT_W,
  localparam int NARROW_W = (IN_W > OUT_W) ? OUT_W : IN_W,
  localparam int RATIO    = WIDE_W / NARROW_W,
  localparam int AW       = $clog2(DEPTH),
  localparam int RL       = $clog2(RATIO),
  localparam int CNT_W    = AW + RL + 1
) (
  input  logic             clk_100,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] in_count,
  output logic [CNT_W-1:0] out_count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam bit PACK   = IN_W < OUT_W;
  localparam bit UNPACK = IN_W > OUT_W;
  localparam int SW     = (RL > 0) ? RL : 1;
  localparam int CW     = AW + 1;
  localparam logic [SW-1:0] LAST = SW'(RATIO - 1);

  logic [WIDE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              flush_pend;
  logic              push;
  logic              commit;
  logic              pop_xfer;
  logic              pop_entry;
  logic [WIDE_W-1:0] commit_dat;
  logic [WIDE_W-1:0] head;

  assign in_ready  = !full && !flush_pend;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop_xfer  = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  if (PACK) begin : g_pack
    logic [IN_W-1:0] acc [RATIO];
    logic [SW-1:0]   acc_n;
    logic            flush_req;
    logic            commit_word;
    logic            commit_flush;

    assign flush_req    = flush || flush_pend;
    assign commit_word  = push && (acc_n == LAST);
    // The word accepted this cycle counts toward the flushed partial entry.
    assign commit_flush = flush_req && !commit_word && (push || acc_n != '0) && !full;
    assign commit       = commit_word || commit_flush;
    assign pop_entry    = pop_xfer;
    assign out_data     = head;
    assign in_count     = (CNT_W'(cnt) << RL) + CNT_W'(acc_n);
    assign out_count    = CNT_W'(cnt);

    always_comb begin
      commit_dat = '0;
      for (int k = 0; k < RATIO; k++) begin
        if (SW'(k) < acc_n)
          commit_dat[k*IN_W +: IN_W] = acc[k];
        else if (push && SW'(k) == acc_n)
          commit_dat[k*IN_W +: IN_W] = in_data;
        else
          commit_dat[k*IN_W +: IN_W] = PAD;
      end
    end

    always_ff @(posedge clk_100) begin
      if (!rst_n || clr) begin
        acc_n      <= '0;
        flush_pend <= 1'b0;
      end else begin
        if (commit)
          acc_n <= '0;
        else if (push)
          acc_n <= acc_n + SW'(1);
        // A flush that could not commit can only have been blocked by a full store.
        if (commit)
          flush_pend <= 1'b0;
        else if (flush && acc_n != '0)
          flush_pend <= 1'b1;
      end
    end

    always_ff @(posedge clk_100) begin
      if (push)
        acc[acc_n] <= in_data;
    end
  end else if (UNPACK) begin : g_unpack
    logic [OUT_W-1:0] lanes [RATIO];
    logic [SW-1:0]    slot;
    logic             unused_flush;

    assign unused_flush = flush;
    assign flush_pend   = 1'b0;
    assign commit       = push;
    assign commit_dat   = in_data;
    assign pop_entry    = pop_xfer && (slot == LAST);
    assign out_data     = lanes[slot];
    assign in_count     = CNT_W'(cnt);
    assign out_count    = (CNT_W'(cnt) << RL) - CNT_W'(slot);

    for (genvar k = 0; k < RATIO; k++) begin : g_lane
      assign lanes[k] = head[k*OUT_W +: OUT_W];
    end

    always_ff @(posedge clk_100) begin
      if (!rst_n || clr)
        slot <= '0;
      else if (pop_xfer)
        slot <= slot + SW'(1);
    end
  end else begin : g_equal
    logic unused_flush;

    assign unused_flush = flush;
    assign flush_pend   = 1'b0;
    assign commit       = push;
    assign commit_dat   = in_data;
    assign pop_entry    = pop_xfer;
    assign out_data     = head;
    assign in_count     = CNT_W'(cnt);
    assign out_count    = CNT_W'(cnt);
  end

  assign cnt_nxt = cnt + CW'(commit) - CW'(pop_entry);

  always_ff @(posedge clk_100) begin
    if (commit)
      mem[wr_ptr] <= commit_dat;
  end

  always_ff @(posedge clk_100) begin
    if (!rst_n || clr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (commit)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_entry)
        rd_ptr <= rd_ptr + AW'(1);
      cnt          <= cnt_nxt;
      full         <= (cnt_nxt == CW'(DEPTH));
      empty        <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= CW'(AF_LEVEL));
      almost_empty <= (cnt_nxt <= CW'(AE_LEVEL));
      if (in_valid && !in_ready)
        overflow <= 1'b1;
      if (out_ready && !out_valid)
        underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_width_fifo.sv
// Bench for ddr3_width_fifo: a pack instance (16->128) and an unpack instance (128->16) against queue-based models.
module tb_ddr3_width_fifo;
  localparam int P_DEPTH = 256;
  localparam int P_AF    = 240;
  localparam int P_AE    = 4;
  localparam int U_DEPTH = 16;
  localparam int U_AF    = 12;
  localparam int U_AE    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         p_clr, p_flush, p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [15:0]  p_in_data;
  logic [127:0] p_out_data;
  logic [11:0]  p_in_count, p_out_count;
  logic         p_full, p_empty, p_af, p_ae, p_ovf, p_unf;

  logic         u_clr, u_flush, u_in_valid, u_in_ready, u_out_valid, u_out_ready;
  logic [127:0] u_in_data;
  logic [15:0]  u_out_data;
  logic [7:0]   u_in_count, u_out_count;
  logic         u_full, u_empty, u_af, u_ae, u_ovf, u_unf;

  int checks   = 0;
  int failures = 0;

  ddr3_width_fifo #(.IN_W(16), .OUT_W(128), .DEPTH(P_DEPTH), .AF_LEVEL(P_AF), .AE_LEVEL(P_AE), .PAD(16'h0)) u_pack (
    .clk_100(clk), .rst_n(rst_n), .clr(p_clr), .flush(p_flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
    .in_count(p_in_count), .out_count(p_out_count), .full(p_full), .empty(p_empty),
    .almost_full(p_af), .almost_empty(p_ae), .overflow(p_ovf), .underflow(p_unf));

  ddr3_width_fifo #(.IN_W(128), .OUT_W(16), .DEPTH(U_DEPTH), .AF_LEVEL(U_AF), .AE_LEVEL(U_AE), .PAD(128'h0)) u_unpack (
    .clk_100(clk), .rst_n(rst_n), .clr(u_clr), .flush(u_flush),
    .in_valid(u_in_valid), .in_ready(u_in_ready), .in_data(u_in_data),
    .out_valid(u_out_valid), .out_ready(u_out_ready), .out_data(u_out_data),
    .in_count(u_in_count), .out_count(u_out_count), .full(u_full), .empty(u_empty),
    .almost_full(u_af), .almost_empty(u_ae), .overflow(u_ovf), .underflow(u_unf));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // Pack model: accepted words collect in a list; eight words (or a flush) become one wide entry.
  logic [15:0]  pm_acc[$];
  logic [127:0] pm_q[$];
  bit           pm_pend, pm_ovf, pm_unf;

  always @(negedge clk) begin : p_mon
    int s0;
    bit ir, ov;
    logic [127:0] w;
    if (!rst_n || p_clr) begin
      pm_acc.delete(); pm_q.delete();
      pm_pend = 0; pm_ovf = 0; pm_unf = 0;
    end else begin
      s0 = pm_q.size();
      ir = (s0 != P_DEPTH) && !pm_pend;
      ov = (s0 != 0);
      chk("p_in_ready",  128'(p_in_ready),  128'(ir));
      chk("p_out_valid", 128'(p_out_valid), 128'(ov));
      chk("p_full",      128'(p_full),      128'(s0 == P_DEPTH));
      chk("p_empty",     128'(p_empty),     128'(s0 == 0));
      chk("p_afull",     128'(p_af),        128'(s0 >= P_AF));
      chk("p_aempty",    128'(p_ae),        128'(s0 <= P_AE));
      chk("p_in_count",  128'(p_in_count),  128'(s0 * 8 + pm_acc.size()));
      chk("p_out_count", 128'(p_out_count), 128'(s0));
      chk("p_overflow",  128'(p_ovf),       128'(pm_ovf));
      chk("p_underflow", 128'(p_unf),       128'(pm_unf));
      if (p_in_valid && !ir) pm_ovf = 1;
      if (p_out_ready && !ov) pm_unf = 1;
      if (ov && p_out_ready) chk("p_data", p_out_data, pm_q.pop_front());
      if (p_in_valid && ir) pm_acc.push_back(p_in_data);
      if (pm_acc.size() == 8 || ((p_flush || pm_pend) && pm_acc.size() > 0)) begin
        if (pm_acc.size() < 8 && s0 == P_DEPTH) begin
          pm_pend = 1;
        end else begin
          w = '0;
          for (int k = 0; k < 8; k++)
            w[k*16 +: 16] = (k < pm_acc.size()) ? pm_acc[k] : 16'h0;
          pm_q.push_back(w);
          pm_acc.delete();
          pm_pend = 0;
        end
      end
    end
  end

  // Unpack model: each accepted wide word becomes eight narrow words, lowest lane first.
  logic [15:0] um_q[$];
  bit          um_ovf, um_unf;

  always @(negedge clk) begin : u_mon
    int s0, ent;
    bit ir, ov;
    if (!rst_n || u_clr) begin
      um_q.delete(); um_ovf = 0; um_unf = 0;
    end else begin
      s0  = um_q.size();
      ent = (s0 + 7) / 8;
      ir  = (ent != U_DEPTH);
      ov  = (s0 != 0);
      chk("u_in_ready",  128'(u_in_ready),  128'(ir));
      chk("u_out_valid", 128'(u_out_valid), 128'(ov));
      chk("u_full",      128'(u_full),      128'(ent == U_DEPTH));
      chk("u_empty",     128'(u_empty),     128'(ent == 0));
      chk("u_afull",     128'(u_af),        128'(ent >= U_AF));
      chk("u_aempty",    128'(u_ae),        128'(ent <= U_AE));
      chk("u_in_count",  128'(u_in_count),  128'(ent));
      chk("u_out_count", 128'(u_out_count), 128'(s0));
      chk("u_overflow",  128'(u_ovf),       128'(um_ovf));
      chk("u_underflow", 128'(u_unf),       128'(um_unf));
      if (u_in_valid && !ir) um_ovf = 1;
      if (u_out_ready && !ov) um_unf = 1;
      if (ov && u_out_ready) chk("u_data", 128'(u_out_data), 128'(um_q.pop_front()));
      if (u_in_valid && ir)
        for (int k = 0; k < 8; k++) um_q.push_back(u_in_data[k*16 +: 16]);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic p_drive(input logic v, input logic [15:0] d, input logic r, input logic f);
    p_in_valid = v; p_in_data = d; p_out_ready = r; p_flush = f;
    step();
  endtask

  task automatic u_drive(input logic v, input logic [127:0] d, input logic r);
    u_in_valid = v; u_in_data = d; u_out_ready = r; u_flush = 1'($urandom_range(1));
    step();
  endtask

  task automatic p_clear();
    p_clr = 1'b1; p_drive(1'b1, 16'hDEAD, 1'b1, 1'b0); p_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    p_clr = 0; p_flush = 0; p_in_valid = 0; p_in_data = '0; p_out_ready = 0;
    u_clr = 0; u_flush = 0; u_in_valid = 0; u_in_data = '0; u_out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Pack: words 1..8 form one entry; then drain it.
    for (int i = 1; i <= 8; i++) p_drive(1'b1, 16'(i), 1'b0, 1'b0);
    p_drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) p_drive(1'b0, '0, 1'b1, 1'b0);

    // Pack: randomized traffic with occasional flush.
    for (int i = 0; i < 1500; i++)
      p_drive(1'($urandom_range(3) != 0), 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(15) == 0));
    repeat (300) p_drive(1'b0, '0, 1'b1, 1'b0);

    // Pack: fill to full, keep pushing for overflow, then drain.
    p_clear();
    for (int i = 0; i < P_DEPTH * 8 + 6; i++) p_drive(1'b1, 16'(i), 1'b0, 1'b0);
    repeat (P_DEPTH + 4) p_drive(1'b0, '0, 1'b1, 1'b0);

    // Pack: partial flush, then flush together with an incoming word.
    p_clear();
    p_drive(1'b1, 16'h000A, 1'b0, 1'b0);
    p_drive(1'b1, 16'h000B, 1'b0, 1'b0);
    p_drive(1'b1, 16'h000C, 1'b0, 1'b0);
    p_drive(1'b0, '0, 1'b0, 1'b1);
    repeat (2) p_drive(1'b0, '0, 1'b0, 1'b0);
    p_drive(1'b1, 16'h0011, 1'b0, 1'b0);
    p_drive(1'b1, 16'h0022, 1'b0, 1'b1);
    p_drive(1'b0, '0, 1'b0, 1'b1);
    repeat (4) p_drive(1'b0, '0, 1'b1, 1'b0);

    // Pack: hold about DEPTH/2 entries with concurrent push and pop.
    p_clear();
    for (int i = 0; i < P_DEPTH * 4; i++) p_drive(1'b1, 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 800; i++) p_drive(1'b1, 16'($urandom), 1'(i % 8 == 0), 1'b0);
    repeat (P_DEPTH) p_drive(1'b0, '0, 1'b1, 1'b0);

    // Pack: clear and reset with a partial accumulator, next entry must be clean.
    for (int i = 0; i < 5; i++) p_drive(1'b1, 16'h0F00 + 16'(i), 1'b0, 1'b0);
    p_clear();
    for (int i = 0; i < 8; i++) p_drive(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) p_drive(1'b1, 16'h0E00 + 16'(i), 1'b0, 1'b0);
    rst_n = 1'b0; p_drive(1'b1, 16'h0BAD, 1'b1, 1'b0); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) p_drive(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
    repeat (4) p_drive(1'b0, '0, 1'b1, 1'b0);
    p_drive(1'b0, '0, 1'b0, 1'b0);

    // Unpack: one wide word returns its lanes 1..8 in order.
    u_drive(1'b1, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b0);
    u_drive(1'b0, '0, 1'b0);
    repeat (10) u_drive(1'b0, '0, 1'b1);

    // Unpack: randomized traffic.
    for (int i = 0; i < 1000; i++)
      u_drive(1'($urandom_range(7) == 0), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(3) != 0));
    repeat (150) u_drive(1'b0, '0, 1'b1);

    // Unpack: fill to full with overflow, drain, then clear mid-entry.
    u_clr = 1'b1; u_drive(1'b0, '0, 1'b0); u_clr = 1'b0;
    for (int i = 0; i < U_DEPTH + 4; i++) u_drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (U_DEPTH * 8 + 4) u_drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 2; i++) u_drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (3) u_drive(1'b0, '0, 1'b1);
    u_clr = 1'b1; u_drive(1'b1, '1, 1'b1); u_clr = 1'b0;
    u_drive(1'b1, 128'h1118_1117_1116_1115_1114_1113_1112_1111, 1'b0);
    repeat (10) u_drive(1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
